// File: rtl/dmem_req_buffer_pkg.sv
// Shared types for the LSQ-to-dcache request buffer: request entry layout,
// memory size encoding and default geometry.
package dmem_req_buffer_pkg;

   localparam int DMEM_DEPTH = 8;
   localparam int DMEM_TAG_W = 6;

   typedef enum logic [1:0] {
      BYTE   = 2'h0,
      HALF   = 2'h1,
      WORD   = 2'h2,
      DOUBLE = 2'h3
   } MEM_SIZE;

   // Tag is kept beside the entry so its width can follow the TAG_W parameter.
   typedef struct packed {
      logic        valid;
      logic        is_store;
      logic [31:0] addr;
      logic [31:0] data;
      logic        is_unsigned;
      MEM_SIZE     size;
      logic        kill;
      logic        issued;
   } DMEM_REQ_ENTRY;

   // A squashed load that never reached the controller is dropped without presenting.
   function automatic logic is_kill_skip(input DMEM_REQ_ENTRY e);
      return e.valid && !e.is_store && e.kill && !e.issued;
   endfunction

endpackage

// File: rtl/dmem_req_fifo.sv
// Two-in / one-out circular buffer of request entries with head/tail/count,
// plus in-place kill marking on squash and issued marking of the head.
module dmem_req_fifo
   import dmem_req_buffer_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int TAG_W = DMEM_TAG_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [1:0]                wr_en,
   input  DMEM_REQ_ENTRY [1:0]       wr_entry,
   input  logic [1:0][TAG_W-1:0]     wr_tag,
   input  logic                      pop,
   input  logic                      squash,
   input  logic                      set_issued,
   output DMEM_REQ_ENTRY             head_entry,
   output logic [TAG_W-1:0]          head_tag,
   output logic [CNT_W-1:0]          count
);

   DMEM_REQ_ENTRY          entries [DEPTH];
   logic [TAG_W-1:0]       tags    [DEPTH];
   logic [PTR_W-1:0]       head;
   logic [PTR_W-1:0]       tail;
   logic [PTR_W-1:0]       tail_1;

   // A lone slot-1 request lands at tail; otherwise slot 1 follows slot 0.
   assign tail_1     = tail + PTR_W'(wr_en[0]);
   assign head_entry = entries[head];
   assign head_tag   = tags[head];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         // NOTE: the whole array is reset so the head reads as an invalid, all-zero entry.
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
            tags[i]    <= '0;
         end
      end else begin
         // NOTE: all state uses <= so later updates below override earlier ones on the same entry.
         for (int i = 0; i < DEPTH; i++) begin
            if (squash && entries[i].valid && !entries[i].is_store)
               entries[i].kill <= 1'b1;
         end
         if (set_issued)
            entries[head].issued <= 1'b1;
         if (pop) begin
            entries[head].valid <= 1'b0;
            head                <= head + PTR_W'(1);
         end
         if (wr_en[0]) begin
            entries[tail] <= wr_entry[0];
            tags[tail]    <= wr_tag[0];
         end
         if (wr_en[1]) begin
            entries[tail_1] <= wr_entry[1];
            tags[tail_1]    <= wr_tag[1];
         end
         tail  <= tail + PTR_W'(wr_en[0]) + PTR_W'(wr_en[1]);
         count <= count + CNT_W'(wr_en[0]) + CNT_W'(wr_en[1]) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/dmem_req_buffer.sv
// Buffers up to two LSQ requests per cycle and presents one at a time to the
// dcache controller; returns completed loads as a registered tagged response.
module dmem_req_buffer
   import dmem_req_buffer_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int TAG_W = DMEM_TAG_W,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [1:0]             in_valid,
   input  logic [1:0]             in_is_store,
   input  logic [1:0][31:0]       in_addr,
   input  logic [1:0][31:0]       in_data,
   input  logic [1:0][2:0]        in_size,
   input  logic [1:0][TAG_W-1:0]  in_tag,
   output logic [1:0]             in_ready,
   input  logic                   squash,
   output logic [31:0]            proc2Dcache_addr,
   output logic [31:0]            proc2Dcache_data,
   output logic [2:0]             proc2Dmem_size,
   output logic                   rd_mem,
   output logic                   wr_mem,
   input  logic [31:0]            dc_data,
   input  logic                   dc_rd_valid,
   input  logic                   dc_wr_valid,
   output logic                   resp_valid,
   output logic [TAG_W-1:0]       resp_tag,
   output logic [31:0]            resp_data,
   output logic [CNT_W-1:0]       count
);

   DMEM_REQ_ENTRY        wr_entry [2];
   DMEM_REQ_ENTRY [1:0]  wr_entry_bus;
   DMEM_REQ_ENTRY        head;
   logic [TAG_W-1:0]     head_tag;
   logic [1:0]           wr_en;
   logic                 skip;
   logic                 pop;
   logic                 set_issued;

   assign in_ready[0] = (count <= CNT_W'(DEPTH - 1));
   assign in_ready[1] = (count <= CNT_W'(DEPTH - 2));
   assign wr_en       = in_valid & in_ready;

   // Loads arriving alongside a squash are born killed.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         wr_entry[k]             = '0;
         wr_entry[k].valid       = 1'b1;
         wr_entry[k].is_store    = in_is_store[k];
         wr_entry[k].addr        = in_addr[k];
         wr_entry[k].data        = in_data[k];
         wr_entry[k].is_unsigned = in_size[k][2];
         wr_entry[k].size        = MEM_SIZE'(in_size[k][1:0]);
         wr_entry[k].kill        = squash && !in_is_store[k];
      end
   end

   assign wr_entry_bus[0] = wr_entry[0];
   assign wr_entry_bus[1] = wr_entry[1];

   dmem_req_fifo #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_entry   (wr_entry_bus),
      .wr_tag     (in_tag),
      .pop        (pop),
      .squash     (squash),
      .set_issued (set_issued),
      .head_entry (head),
      .head_tag   (head_tag),
      .count      (count)
   );

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      rd_mem           = 1'b0;
      wr_mem           = 1'b0;
      proc2Dcache_addr = '0;
      proc2Dcache_data = '0;
      proc2Dmem_size   = '0;
      skip             = is_kill_skip(head);
      if (head.valid) begin
         proc2Dcache_addr = head.addr;
         proc2Dcache_data = head.data;
         proc2Dmem_size   = {head.is_unsigned, head.size};
         if (head.is_store)
            wr_mem = 1'b1;
         else if (!skip)
            rd_mem = 1'b1;
      end
   end

   // An issued load stays presented (even once killed) until the controller finishes it.
   assign pop        = (wr_mem && dc_wr_valid) || (rd_mem && dc_rd_valid) || skip;
   assign set_issued = rd_mem && !dc_rd_valid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_valid <= 1'b0;
         resp_tag   <= '0;
         resp_data  <= '0;
      end else begin
         resp_valid <= rd_mem && dc_rd_valid && !head.kill;
         if (rd_mem && dc_rd_valid) begin
            resp_tag  <= head_tag;
            resp_data <= dc_data;
         end
      end
   end

endmodule

// File: doc/dmem_req_buffer.md
# dmem_req_buffer

- Sits between the two-wide LSQ and the dcache controller.
- Each cycle it accepts up to two memory requests in program order: loads, and committed stores.
- It holds them in a circular buffer and presents exactly one request at a time on the controller's request bus. The head request stays stable until the controller returns its valid, and completed loads go back to the LSQ as a registered response carrying the load's tag.
- Squashed loads are cancelled without disturbing a miss already in flight.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥ 4.
- TAG_W, 6, width of the LSQ/ROB tag carried with each request.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  asynchronous, active-low: asserting it low clears the block immediately.
- in_valid  in  2  per-slot request valid; slot 0 is older than slot 1.
- in_is_store  in  2  per-slot: 1 = store, 0 = load.
- in_addr  in  2×32  per-slot byte address.
- in_data  in  2×32  per-slot store data; ignored for loads.
- in_size  in  2×3  per-slot size: [1:0] = MEM_SIZE, [2] = unsigned load.
- in_tag  in  2×TAG_W  per-slot tag, returned with the load response.
- in_ready  out  2  in_ready[0] = count ≤ DEPTH-1; in_ready[1] = count ≤ DEPTH-2.
- squash  in  1  kill all loads that are buffered or arriving this cycle.
- proc2Dcache_addr  out  32  head address.
- proc2Dcache_data  out  32  head store data.
- proc2Dmem_size  out  3  head size.
- rd_mem  out  1  head is a load to be presented.
- wr_mem  out  1  head is a store.
- dc_data  in  32  sized load data from the controller.
- dc_rd_valid  in  1  load complete this cycle.
- dc_wr_valid  in  1  store accepted this cycle.
- resp_valid  out  1  load response valid.
- resp_tag  out  TAG_W  tag of the responding load.
- resp_data  out  32  load data.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
Entry fields: valid, is_store, addr, data, size, tag, kill, issued.

Enqueue (posedge):
- A valid slot k is written only if in_ready[k]; the LSQ never asserts in_valid[k] without in_ready[k].
- Slot 0 is written at tail and slot 1 after it. If only slot 1 is valid, it is written at tail.
- Tail advances by the number written, modulo DEPTH.

Head presentation (combinational from head registers):
- Live store: wr_mem = 1.
- Live load (not killed, or killed and issued): rd_mem = 1.
- Killed, unissued load: rd_mem = wr_mem = 0, and the entry pops that cycle.
- Empty: all request outputs are 0.
- Address, data and size always mirror the head entry. rd_mem and wr_mem are never 1 together.

Pop:
- Head pops at posedge when dc_wr_valid (store), dc_rd_valid (load), or on the killed-unissued skip. At most one pop per cycle.

Issued bit:
- Set at posedge when the head presents rd_mem and dc_rd_valid = 0, i.e. a miss in progress.
- An issued load must keep rd_mem and its address held until dc_rd_valid arrives; it is never dropped.

Response:
- On a load pop with kill = 0, next cycle resp_valid = 1 with resp_tag = entry tag and resp_data = dc_data captured at the pop.
- Killed loads produce no response. Stores produce no response.

Squash:
- Sets kill on every buffered load, including the head.
- Loads enqueued in the same cycle are written with kill = 1.
- Stores are never affected.

count:
- count_next = count + written − popped.
- Simultaneous enqueue and pop are legal, including when count = DEPTH (pop only, since in_ready = 0).

## Timing
- Request accepted at edge N; if the buffer was empty it is presented during cycle N+1.
- Hit load or store completes in that same cycle. A load response appears in cycle N+2.
- A miss holds the head for the controller's full request/wait latency.
- Throughput is one request per cycle.
- Reset (low): all entries invalid and pointers = 0 immediately. Outputs: count = 0, rd_mem = wr_mem = 0, all address/data/size = 0, resp_valid = 0, resp_tag = 0, resp_data = 0.
- Reset mid-miss abandons the request; the controller is reset by the same event.

## Structure
- Shared package: DMEM_REQ_ENTRY struct, MEM_SIZE use, and the DEPTH/TAG_W defaults alongside the existing dcache macros.
- One sub-module, dmem_req_fifo: storage plus head/tail/count for the two-in/one-out circular buffer.
- Presentation, issued/kill handling and the response register live in the top module.

## Test plan
- Two loads enqueued together into an empty buffer, both hitting: rd_mem in cycles 1 and 2; responses in cycles 2 and 3 with tags 3 then 4, in order.
- Store to 0x1000 with data 0xDEADBEEF, then a load: wr_mem = 1 with the address and data stable; the load is presented the cycle after dc_wr_valid.
- Load miss (dc_rd_valid held 0 for 20 cycles): rd_mem and addr stay constant throughout; pop and response follow dc_rd_valid.
- Squash during an issued miss, with 3 loads and 1 store queued: the head keeps rd_mem until dc_rd_valid with no response; the 3 killed loads are skipped at one per cycle with no response; the store still issues.
- Fill to DEPTH = 8: in_ready = 00 at count 8 and 01 at count 7; a simultaneous pop and single enqueue keeps count at 7; wrap-around preserves order.
- Reset driven low mid-miss at count 5: count = 0 and rd_mem = 0 immediately; no response after reset is released.
